// File: rtl/quantizer_mc.sv
// -----------------------------------------------------------------------------
// quantizer_mc
//   Multi-channel requantizer between the accumulator/ReLU stage and the next
//   layer's input buffer. Each beat carries N_CH accumulator lanes. Each lane is
//   right-shifted by a runtime amount, optionally rounded half-up, interpreted
//   as signed or unsigned, and saturated to O_BW bits. Two-stage valid/ready
//   pipeline with backpressure, plus a per-frame count of saturated beats.
//
// Ports
//   clk_i        clock
//   rst_n_i      asynchronous active-low reset
//   shift_i      right-shift amount, captured with each accepted beat
//   signed_i     1 = lanes are two's complement, 0 = unsigned (per beat)
//   round_i      1 = add half an LSB of the result before shifting (per beat)
//   data_i       input lanes, lane c = data_i[c*I_BW +: I_BW]
//   valid_i      input beat valid
//   last_i       final beat of frame
//   ready_o      block can accept a beat (combinational)
//   data_o       quantized lanes, same ordering as data_i
//   valid_o      output beat valid
//   last_o       last flag aligned with data_o
//   ready_i      downstream ready
//   sat_cnt_o    saturated beats in the last completed frame
//   sat_valid_o  one-cycle pulse when sat_cnt_o updates
// -----------------------------------------------------------------------------
module quantizer_mc #(
    parameter int N_CH     = 4,
    parameter int I_BW     = 32,
    parameter int O_BW     = 8,
    parameter int SHIFT_BW = $clog2(I_BW),
    parameter int CNT_BW   = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [SHIFT_BW-1:0]    shift_i,
    input  logic                   signed_i,
    input  logic                   round_i,
    input  logic [N_CH*I_BW-1:0]   data_i,
    input  logic                   valid_i,
    input  logic                   last_i,
    output logic                   ready_o,
    output logic [N_CH*O_BW-1:0]   data_o,
    output logic                   valid_o,
    output logic                   last_o,
    input  logic                   ready_i,
    output logic [CNT_BW-1:0]      sat_cnt_o,
    output logic                   sat_valid_o
);

    // One extra bit keeps the rounding add from overflowing in either mode.
    localparam int E_BW = I_BW + 1;

    localparam logic [E_BW-1:0]     ONE_E   = {{I_BW{1'b0}}, 1'b1};
    localparam logic [SHIFT_BW-1:0] ONE_S   = {{(SHIFT_BW-1){1'b0}}, 1'b1};
    localparam logic [SHIFT_BW-1:0] ZERO_S  = {SHIFT_BW{1'b0}};
    // Largest positive output, 2^(O_BW-1)-1, held at the extended width.
    localparam logic [E_BW-1:0]     POS_LIM = {{(E_BW-O_BW+1){1'b0}}, {(O_BW-1){1'b1}}};
    // Most negative output, -2^(O_BW-1), is the bitwise inverse of POS_LIM.
    localparam logic [E_BW-1:0]     NEG_LIM = ~POS_LIM;
    localparam logic [O_BW-1:0]     OUT_MAX = {1'b0, {(O_BW-1){1'b1}}};
    localparam logic [O_BW-1:0]     OUT_MIN = {1'b1, {(O_BW-1){1'b0}}};
    localparam logic [CNT_BW-1:0]   CNT_MAX = {CNT_BW{1'b1}};
    localparam logic [CNT_BW-1:0]   CNT_ONE = {{(CNT_BW-1){1'b0}}, 1'b1};

    // Extend, optionally round, then shift one lane.
    function automatic logic [E_BW-1:0] scale_lane(
        input logic [I_BW-1:0]     x,
        input logic [SHIFT_BW-1:0] s,
        input logic                sgn,
        input logic                rnd
    );
        logic [E_BW-1:0] ext_s;
        logic [E_BW-1:0] bias_s;
        logic [E_BW-1:0] sum_s;
        logic [E_BW-1:0] res_s;
        if (sgn) begin
            ext_s = {x[I_BW-1], x};
        end else begin
            ext_s = {1'b0, x};
        end
        if (rnd && (s != ZERO_S)) begin
            bias_s = ONE_E << (s - ONE_S);
        end else begin
            bias_s = {E_BW{1'b0}};
        end
        sum_s = ext_s + bias_s;
        if (sgn) begin
            res_s = $unsigned($signed(sum_s) >>> s);
        end else begin
            res_s = sum_s >> s;
        end
        return res_s;
    endfunction

    // Clamp one scaled lane; MSB of the result is the "clamped" flag.
    // Unsigned lanes only clamp high so the int8 consumer never sees a
    // negative value.
    function automatic logic [O_BW:0] sat_lane(
        input logic [E_BW-1:0] v,
        input logic            sgn
    );
        logic [O_BW:0] res_s;
        if (sgn) begin
            if ($signed(v) > $signed(POS_LIM)) begin
                res_s = {1'b1, OUT_MAX};
            end else if ($signed(v) < $signed(NEG_LIM)) begin
                res_s = {1'b1, OUT_MIN};
            end else begin
                res_s = {1'b0, v[O_BW-1:0]};
            end
        end else begin
            if (v > POS_LIM) begin
                res_s = {1'b1, OUT_MAX};
            end else begin
                res_s = {1'b0, v[O_BW-1:0]};
            end
        end
        return res_s;
    endfunction

    logic                       s1_valid_r;
    logic [N_CH-1:0][E_BW-1:0]  s1_val_r;
    logic                       s1_signed_r;
    logic                       s1_last_r;
    logic                       s2_sat_r;
    logic [CNT_BW-1:0]          cnt_r;

    logic                       s2_load_s;
    logic                       out_fire_s;
    logic [N_CH-1:0][E_BW-1:0]  s1_next_s;
    logic [N_CH*O_BW-1:0]       s2_next_s;
    logic [N_CH-1:0]            lane_clamp_s;
    logic                       sat_any_s;
    logic [O_BW:0]              lane_res_s;
    logic [CNT_BW-1:0]          cnt_inc_s;

    // Handshake and stall control.
    always_comb begin
        s2_load_s  = !valid_o || ready_i;
        ready_o    = !s1_valid_r || s2_load_s;
        out_fire_s = valid_o && ready_i;
    end

    // Per-lane arithmetic for both stages.
    always_comb begin
        s1_next_s    = {(N_CH*E_BW){1'b0}};
        s2_next_s    = {(N_CH*O_BW){1'b0}};
        lane_clamp_s = {N_CH{1'b0}};
        lane_res_s   = {(O_BW+1){1'b0}};
        for (int c = 0; c < N_CH; c++) begin
            s1_next_s[c] = scale_lane(data_i[c*I_BW +: I_BW], shift_i, signed_i, round_i);
            lane_res_s   = sat_lane(s1_val_r[c], s1_signed_r);
            lane_clamp_s[c] = lane_res_s[O_BW];
            s2_next_s[c*O_BW +: O_BW] = lane_res_s[O_BW-1:0];
        end
        sat_any_s = |lane_clamp_s;
    end

    // Saturated-beat count including the beat currently on the output.
    always_comb begin
        if (s2_sat_r && (cnt_r != CNT_MAX)) begin
            cnt_inc_s = cnt_r + CNT_ONE;
        end else begin
            cnt_inc_s = cnt_r;
        end
    end

    // Stage 1: scaled lanes plus the mode and last bits the next stage needs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid_r  <= 1'b0;
            s1_val_r    <= {(N_CH*E_BW){1'b0}};
            s1_signed_r <= 1'b0;
            s1_last_r   <= 1'b0;
        end else if (ready_o) begin
            s1_valid_r <= valid_i;
            if (valid_i) begin
                s1_val_r    <= s1_next_s;
                s1_signed_r <= signed_i;
                s1_last_r   <= last_i;
            end
        end
    end

    // Stage 2: saturated output; data only changes when a real beat moves in,
    // so it is held stable through stalls and idle gaps.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_o  <= 1'b0;
            last_o   <= 1'b0;
            data_o   <= {(N_CH*O_BW){1'b0}};
            s2_sat_r <= 1'b0;
        end else if (s2_load_s) begin
            valid_o <= s1_valid_r;
            last_o  <= s1_valid_r && s1_last_r;
            if (s1_valid_r) begin
                data_o   <= s2_next_s;
                s2_sat_r <= sat_any_s;
            end
        end
    end

    // Frame statistics: count saturated output beats, publish on last.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_r       <= {CNT_BW{1'b0}};
            sat_cnt_o   <= {CNT_BW{1'b0}};
            sat_valid_o <= 1'b0;
        end else if (out_fire_s) begin
            if (last_o) begin
                sat_cnt_o   <= cnt_inc_s;
                sat_valid_o <= 1'b1;
                cnt_r       <= {CNT_BW{1'b0}};
            end else begin
                cnt_r       <= cnt_inc_s;
                sat_valid_o <= 1'b0;
            end
        end else begin
            sat_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_quantizer_mc.sv
// -----------------------------------------------------------------------------
// tb_quantizer_mc
//   Self-checking bench for quantizer_mc. A queue-based reference model
//   computes each lane with plain integer arithmetic when a beat is accepted;
//   every cycle the bench predicts ready_o, valid_o, data_o, last_o and the
//   frame-statistics pulse and compares them through one checking task.
// -----------------------------------------------------------------------------
module tb_quantizer_mc;

    localparam int N_CH     = 4;
    localparam int I_BW     = 32;
    localparam int O_BW     = 8;
    localparam int SHIFT_BW = 5;
    localparam int CNT_BW   = 16;
    localparam int CNT_MAX  = 65535;

    logic                  clk_i;
    logic                  rst_n_i;
    logic [SHIFT_BW-1:0]   shift_i;
    logic                  signed_i;
    logic                  round_i;
    logic [N_CH*I_BW-1:0]  data_i;
    logic                  valid_i;
    logic                  last_i;
    logic                  ready_o;
    logic [N_CH*O_BW-1:0]  data_o;
    logic                  valid_o;
    logic                  last_o;
    logic                  ready_i;
    logic [CNT_BW-1:0]     sat_cnt_o;
    logic                  sat_valid_o;

    quantizer_mc #(
        .N_CH(N_CH), .I_BW(I_BW), .O_BW(O_BW), .SHIFT_BW(SHIFT_BW), .CNT_BW(CNT_BW)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .shift_i(shift_i), .signed_i(signed_i),
        .round_i(round_i), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
        .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .last_o(last_o),
        .ready_i(ready_i), .sat_cnt_o(sat_cnt_o), .sat_valid_o(sat_valid_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [N_CH*O_BW-1:0] data;
        logic                 last;
        logic                 sat;
        int                   acc;
    } beat_t;

    beat_t q[$];
    int    cyc;
    int    frame_cnt;
    logic  pend_pulse;
    int    pend_cnt;
    int    checks;
    int    errors;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: integer arithmetic on each lane, then clamp.
    function automatic void model_beat(input logic [N_CH*I_BW-1:0] d, input int s,
                                       input logic sg, input logic rn,
                                       output logic [N_CH*O_BW-1:0] o, output logic sat);
        longint v;
        longint pmax;
        longint nmin;
        logic [I_BW-1:0] x;
        pmax = (longint'(1) << (O_BW - 1)) - 1;
        nmin = -(longint'(1) << (O_BW - 1));
        o = '0;
        sat = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            x = d[c*I_BW +: I_BW];
            if (sg) v = longint'($signed(x));
            else    v = longint'({32'd0, x});
            if (rn && s > 0) v = v + (longint'(1) << (s - 1));
            v = v >>> s;
            if (v > pmax) begin
                o[c*O_BW +: O_BW] = pmax[O_BW-1:0];
                sat = 1'b1;
            end else if (v < nmin) begin
                o[c*O_BW +: O_BW] = nmin[O_BW-1:0];
                sat = 1'b1;
            end else begin
                o[c*O_BW +: O_BW] = v[O_BW-1:0];
            end
        end
    endfunction

    // One clock: predict and compare at the falling edge, update the model.
    task automatic step(input logic rd, output logic acc);
        logic  exp_rdy;
        logic  exp_valid;
        beat_t b;
        ready_i = rd;
        @(negedge clk_i);
        exp_rdy   = (q.size() < 2) || rd;
        exp_valid = (q.size() > 0) && ((cyc - q[0].acc) >= 2);
        check_eq("ready_o", ready_o, exp_rdy);
        check_eq("valid_o", valid_o, exp_valid);
        if (exp_valid) begin
            check_eq("data_o", data_o, q[0].data);
            check_eq("last_o", last_o, q[0].last);
        end
        check_eq("sat_valid_o", sat_valid_o, pend_pulse);
        if (pend_pulse) check_eq("sat_cnt_o", sat_cnt_o, pend_cnt);
        pend_pulse = 1'b0;
        if (exp_valid && rd) begin
            b = q.pop_front();
            if (b.sat && frame_cnt < CNT_MAX) frame_cnt++;
            if (b.last) begin
                pend_pulse = 1'b1;
                pend_cnt   = frame_cnt;
                frame_cnt  = 0;
            end
        end
        acc = valid_i && exp_rdy;
        if (acc) begin
            model_beat(data_i, int'(shift_i), signed_i, round_i, b.data, b.sat);
            b.last = last_i;
            b.acc  = cyc;
            q.push_back(b);
        end
        cyc++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [N_CH*I_BW-1:0] d, input int s, input logic sg,
                        input logic rn, input logic ls, input int rdy_pct);
        logic acc;
        int   tries;
        data_i   = d;
        shift_i  = SHIFT_BW'(s);
        signed_i = sg;
        round_i  = rn;
        last_i   = ls;
        valid_i  = 1'b1;
        acc      = 1'b0;
        tries    = 0;
        while (!acc && tries < 64) begin
            step(int'($urandom_range(0, 99)) < rdy_pct, acc);
            tries++;
        end
        valid_i = 1'b0;
        if (!acc) check_eq("accept_timeout", {63'd0, acc}, 64'd1);
    endtask

    task automatic drain(input int n);
        logic acc;
        valid_i = 1'b0;
        for (int i = 0; i < n; i++) step(1'b1, acc);
    endtask

    function automatic logic [I_BW-1:0] rand_lane();
        logic [I_BW-1:0] t;
        case ($urandom_range(0, 3))
            0: t = $urandom;
            1: t = $urandom_range(0, 4000);
            2: t = 32'd0 - 32'($urandom_range(0, 4000));
            3: begin
                case ($urandom_range(0, 3))
                    0: t = 32'h7FFF_FFFF;
                    1: t = 32'h8000_0000;
                    2: t = 32'hFFFF_FFFF;
                    default: t = 32'h0000_0000;
                endcase
            end
            default: t = 32'd0;
        endcase
        return t;
    endfunction

    function automatic logic [N_CH*I_BW-1:0] rand_beat();
        logic [N_CH*I_BW-1:0] d;
        for (int c = 0; c < N_CH; c++) d[c*I_BW +: I_BW] = rand_lane();
        return d;
    endfunction

    function automatic int rand_shift();
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 8));
        return int'($urandom_range(0, 31));
    endfunction

    initial begin
        logic acc;
        int   beats;
        int   k;
        checks = 0; errors = 0; cyc = 0; frame_cnt = 0;
        pend_pulse = 1'b0; pend_cnt = 0;
        rst_n_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
        shift_i = '0; signed_i = 1'b0; round_i = 1'b0; last_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check_eq("rst_valid_o", valid_o, 1'b0);
        check_eq("rst_last_o", last_o, 1'b0);
        check_eq("rst_data_o", data_o, 32'h0);
        check_eq("rst_sat_cnt_o", sat_cnt_o, 16'h0);
        check_eq("rst_sat_valid_o", sat_valid_o, 1'b0);
        check_eq("rst_ready_o", ready_o, 1'b1);
        rst_n_i = 1'b1;
        drain(2);

        // Frame statistics: beats 1 and 3 saturate, last on beat 3.
        send({4{32'h0000_0100}}, 0, 1'b0, 1'b0, 1'b0, 100);
        send({4{32'h0000_0001}}, 0, 1'b0, 1'b0, 1'b0, 100);
        send({4{32'h0000_0200}}, 1, 1'b0, 1'b0, 1'b1, 100);
        drain(3);
        check_eq("frame_cnt2", sat_cnt_o, 16'd2);
        send({4{32'h0000_0003}}, 0, 1'b0, 1'b0, 1'b1, 100);
        drain(3);
        check_eq("frame_cnt0", sat_cnt_o, 16'd0);

        // Unsigned s=4: 0x7F0 -> 7F, 0x800 -> clamps, 0x10 -> 01, 0 -> 00.
        send({32'h0, 32'h10, 32'h800, 32'h7F0}, 4, 1'b0, 1'b0, 1'b0, 100);
        drain(2);
        check_eq("uns_s4", data_o, 32'h0001_7F7F);
        // Signed s=2: -12 -> FD, -1024 -> clamps to 80.
        send({32'h0, 32'h7FFF_FFFF, 32'hFFFF_FC00, 32'hFFFF_FFF4}, 2, 1'b1, 1'b0, 1'b0, 100);
        drain(2);
        check_eq("sgn_s2", data_o, 32'h007F_80FD);
        send({32'hFFFF_FFFF, 32'h8000_0000, 32'h5, 32'h7FFF_FFFF}, 0, 1'b1, 1'b0, 1'b0, 100);
        drain(2);
        check_eq("sgn_s0", data_o, 32'hFF80_057F);
        // Rounding half up.
        send({32'h0, 32'h2, 32'h1, 32'h3}, 1, 1'b0, 1'b1, 1'b0, 100);
        drain(2);
        check_eq("rnd_uns_s1", data_o, 32'h0001_0102);
        send({32'h0, 32'hFFFF_FFFC, 32'h3, 32'hFFFF_FFFD}, 1, 1'b1, 1'b1, 1'b0, 100);
        drain(2);
        check_eq("rnd_sgn_s1", data_o, 32'h00FE_02FF);
        send({32'h0, 32'h0, 32'h0, 32'h5}, 0, 1'b0, 1'b1, 1'b0, 100);
        drain(2);
        check_eq("rnd_s0", data_o, 32'h0000_0005);
        send({4{32'hFFFF_FFFF}}, 4, 1'b0, 1'b1, 1'b1, 100);
        drain(3);
        check_eq("rnd_nowrap", data_o, 32'h7F7F_7F7F);

        // Backpressure: downstream stalled for 5 cycles while 6 beats are offered.
        beats = 0; k = 0;
        data_i = rand_beat(); shift_i = SHIFT_BW'(rand_shift());
        signed_i = 1'($urandom_range(0, 1)); round_i = 1'($urandom_range(0, 1));
        last_i = 1'b0; valid_i = 1'b1;
        while (beats < 6 && k < 100) begin
            step(k >= 5, acc);
            if (acc) begin
                beats++;
                data_i = rand_beat(); shift_i = SHIFT_BW'(rand_shift());
                signed_i = 1'($urandom_range(0, 1)); round_i = 1'($urandom_range(0, 1));
                last_i = (beats == 5);
            end
            k++;
        end
        valid_i = 1'b0;
        drain(4);

        // Randomized stream with random backpressure and frame boundaries.
        for (int i = 0; i < 400; i++) begin
            send(rand_beat(), rand_shift(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) == 0), int'($urandom_range(40, 100)));
            if ($urandom_range(0, 7) == 0) begin
                ready_i = 1'b1;
                step(1'($urandom_range(0, 1)), acc);
            end
        end
        drain(6);
        check_eq("drain_empty", q.size(), 0);

        // Asynchronous reset with two beats in flight.
        send({4{32'h0001_0000}}, 0, 1'b0, 1'b0, 1'b1, 100);
        drain(3);
        send({4{32'h0001_0000}}, 0, 1'b1, 1'b0, 1'b0, 0);
        send({4{32'h0002_0000}}, 0, 1'b1, 1'b0, 1'b0, 0);
        ready_i = 1'b0;
        #2;
        rst_n_i = 1'b0;
        #1;
        check_eq("arst_valid_o", valid_o, 1'b0);
        check_eq("arst_last_o", last_o, 1'b0);
        check_eq("arst_data_o", data_o, 32'h0);
        check_eq("arst_sat_cnt_o", sat_cnt_o, 16'h0);
        check_eq("arst_sat_valid_o", sat_valid_o, 1'b0);
        check_eq("arst_ready_o", ready_o, 1'b1);
        q.delete();
        frame_cnt = 0;
        pend_pulse = 1'b0;
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        drain(3);
        send({4{32'h0000_0080}}, 0, 1'b0, 1'b0, 1'b1, 100);
        drain(3);
        check_eq("post_rst_cnt", sat_cnt_o, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
